// File: rtl/issue_select.sv
// Issue select: scans the reservation-station view round-robin, grants up to
// N ready entries under per-functional-unit caps, frees them in the RS with a
// zero-latency issuing vector and registers the grants into N issue slots.
//
// Handshake: there is no ready/valid pair on the issue side. An RS entry is
// offered when rs_valid[j] is high; it is taken exactly when
// rs_data_issuing[j] is high in the same cycle, and the RS frees it at the
// next clock edge. Issue slots carry no backpressure: iss_valid[k] is a
// one-cycle pulse per packet and the execute stage must accept it.

package issue_select_pkg;

  localparam int B_MASK_W  = 4;
  localparam int SQ_MASK_W = 4;
  localparam int TAG_W     = 8;

  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_MULT  = 2'd1,
    FU_LOAD  = 2'd2,
    FU_STORE = 2'd3
  } fu_type_t;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic                 Source1_ready;
    logic                 Source2_ready;
    fu_type_t             fu_type;
    logic [B_MASK_W-1:0]  b_mask;
    logic [SQ_MASK_W-1:0] sq_mask;
  } RS_PACKET;

endpackage

module issue_select
  import issue_select_pkg::*;
#(
  parameter int RS_SZ    = 16,
  parameter int N        = 2,
  parameter int NUM_ALU  = 2,
  parameter int MULT_LAT = 4,
  parameter int NUM_LS   = 1,
  localparam int PTR_W   = (RS_SZ > 1) ? $clog2(RS_SZ) : 1,
  localparam int CNT_W   = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  RS_PACKET            rs_data [RS_SZ],
  input  logic [RS_SZ-1:0]    rs_valid,
  input  logic                ls_ready,
  input  logic [B_MASK_W-1:0] b_mm_resolve,
  input  logic                b_mm_mispred,
  output logic [RS_SZ-1:0]    rs_data_issuing,
  output RS_PACKET            iss_packet [N],
  output logic [N-1:0]        iss_valid,
  output logic                mult_busy,
  // observation of internal scan state
  output logic [PTR_W-1:0]    o_rr_ptr,
  output logic [CNT_W-1:0]    o_mult_cnt
);

  logic [PTR_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_mult_cnt;
  RS_PACKET         r_iss_packet [N];
  logic [N-1:0]     r_iss_valid;

  logic [RS_SZ-1:0] w_issuing;
  logic [PTR_W-1:0] w_slot_idx [N];
  logic [N-1:0]     w_slot_vld;
  logic             w_any_grant;
  logic             w_mult_grant;
  logic [PTR_W-1:0] w_last_idx;

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_elig;
  logic             w_cap_ok;
  int               w_n_tot;
  int               w_n_alu;
  int               w_n_mul;
  int               w_n_ls;

  RS_PACKET         w_slot_pkt [N];
  logic [N-1:0]     w_slot_kill;

  // Round-robin scan from r_rr_ptr: first eligible entries within caps win.
  always_comb begin
    w_issuing    = '0;
    w_slot_vld   = '0;
    w_any_grant  = 1'b0;
    w_mult_grant = 1'b0;
    w_last_idx   = '0;
    w_sum        = '0;
    w_idx        = '0;
    w_elig       = 1'b0;
    w_cap_ok     = 1'b0;
    w_n_tot      = 0;
    w_n_alu      = 0;
    w_n_mul      = 0;
    w_n_ls       = 0;
    for (int k = 0; k < N; k++) begin
      w_slot_idx[k] = '0;
    end
    for (int i = 0; i < RS_SZ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(RS_SZ)) begin
        w_sum = w_sum - (PTR_W+1)'(RS_SZ);
      end
      w_idx = w_sum[PTR_W-1:0];
      w_elig   = 1'b0;
      w_cap_ok = 1'b0;
      case (rs_data[w_idx].fu_type)
        FU_ALU: begin
          w_elig   = 1'b1;
          w_cap_ok = (w_n_alu < NUM_ALU);
        end
        FU_MULT: begin
          w_elig   = (r_mult_cnt == '0);
          w_cap_ok = (w_n_mul < 1);
        end
        FU_LOAD: begin
          w_elig   = ls_ready && (rs_data[w_idx].sq_mask == '0);
          w_cap_ok = (w_n_ls < NUM_LS);
        end
        default: begin
          w_elig   = ls_ready;
          w_cap_ok = (w_n_ls < NUM_LS);
        end
      endcase
      w_elig = w_elig && rs_valid[w_idx] && rs_data[w_idx].Source1_ready
               && rs_data[w_idx].Source2_ready;
      if (!reset && w_elig && w_cap_ok && (w_n_tot < N)) begin
        w_issuing[w_idx] = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (w_n_tot == k) begin
            w_slot_idx[k] = w_idx;
            w_slot_vld[k] = 1'b1;
          end
        end
        w_n_tot     = w_n_tot + 1;
        w_any_grant = 1'b1;
        w_last_idx  = w_idx;
        case (rs_data[w_idx].fu_type)
          FU_ALU:  w_n_alu = w_n_alu + 1;
          FU_MULT: begin
            w_n_mul      = w_n_mul + 1;
            w_mult_grant = 1'b1;
          end
          default: w_n_ls = w_n_ls + 1;
        endcase
      end
    end
  end

  // Per-slot packet with resolving branch bit cleared, plus squash decision.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_slot_pkt[k]        = rs_data[w_slot_idx[k]];
      w_slot_pkt[k].b_mask = rs_data[w_slot_idx[k]].b_mask & ~b_mm_resolve;
      w_slot_kill[k]       = b_mm_mispred
                             && ((rs_data[w_slot_idx[k]].b_mask & b_mm_resolve) != '0);
    end
  end

  // Issue slots: one-cycle registered copies of this cycle's grants.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_iss_valid <= '0;
      for (int k = 0; k < N; k++) begin
        r_iss_packet[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r_iss_packet[k] <= w_slot_pkt[k];
        r_iss_valid[k]  <= w_slot_vld[k] && !w_slot_kill[k];
      end
    end
  end

  // Round-robin pointer moves just past the last granted entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      if (w_last_idx == PTR_W'(RS_SZ - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_last_idx + PTR_W'(1);
      end
    end
  end

  // Multiplier occupancy countdown; a squashed MULT still occupies the unit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mult_cnt <= '0;
    end else if (w_mult_grant) begin
      r_mult_cnt <= CNT_W'(MULT_LAT - 1);
    end else if (r_mult_cnt != '0) begin
      r_mult_cnt <= r_mult_cnt - CNT_W'(1);
    end
  end

  assign rs_data_issuing = w_issuing;
  assign iss_packet      = r_iss_packet;
  assign iss_valid       = r_iss_valid;
  assign mult_busy       = (r_mult_cnt != '0);
  assign o_rr_ptr        = r_rr_ptr;
  assign o_mult_cnt      = r_mult_cnt;

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Consumer end of the reservation-station issue interface.
- Each cycle it scans the RS view (rs_data_next / rs_valid_issue) and picks up to N ready entries, subject to functional-unit availability.
- It drives the rs_data_issuing bit vector back to the RS so granted entries are freed at the same edge.
- Granted packets are registered into N issue slots that feed the execute stage.

Parameters:
RS_SZ, 16, number of RS entries scanned
N, 2, issue width (number of issue slots)
NUM_ALU, 2, max ALU-type grants per cycle
MULT_LAT, 4, cycles the single non-pipelined multiplier stays busy per issue (>=1)
NUM_LS, 1, max load/store grants per cycle

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
rs_data  input  RS_PACKET[RS_SZ]  RS entry view; fields used: Source1_ready, Source2_ready, fu_type, b_mask, sq_mask
rs_valid  input  RS_SZ  per-entry valid (already squash-filtered by RS)
ls_ready  input  1  load/store unit can accept this cycle
b_mm_resolve  input  B_MASK_MASK  branch bit resolving this cycle
b_mm_mispred  input  1  resolving branch mispredicted
rs_data_issuing  output  RS_SZ  combinational one-hot-per-grant vector of entries issued this cycle
iss_packet  output  RS_PACKET[N]  registered issue slots
iss_valid  output  N  slot valid
mult_busy  output  1  multiplier occupied (counter != 0)

Behaviour:
- fu_type encoding: 0 ALU, 1 MULT, 2 LOAD, 3 STORE.
- Eligibility: rs_valid[j] && Source1_ready && Source2_ready, plus the per-type condition:
  - ALU: always eligible.
  - MULT: mult counter == 0.
  - LOAD: ls_ready && sq_mask == 0.
  - STORE: ls_ready.
- Scan order: start at rr_ptr, ascending, wrapping modulo RS_SZ. The first eligible entries win, under these caps:
  - total grants <= N
  - ALU grants <= NUM_ALU
  - MULT grants <= 1
  - LOAD + STORE grants <= NUM_LS
- An eligible entry that exceeds its cap is skipped; later entries of other types may still win.
- Slot k receives the k-th grant in scan order. Unused slots are invalid.
- rs_data_issuing[j] = 1 exactly for granted j, in the same cycle (zero latency); it is 0 while reset is high.
- Issue register, latency 1:
  - At the edge, iss_packet[k] <= granted packet with b_mask cleared by ~b_mm_resolve.
  - iss_valid[k] <= 1 if a grant exists, unless b_mm_mispred && (packet.b_mask & b_mm_resolve) != 0, in which case iss_valid[k] <= 0.
- Slots carry no backpressure: each slot holds for exactly one cycle, then is overwritten or invalidated.
- rr_ptr:
  - On any grant, rr_ptr <= (index of last grant + 1) mod RS_SZ.
  - With no grant, rr_ptr is unchanged.
  - Width is clog2(RS_SZ); wrap from RS_SZ-1 goes to 0.
- Multiplier counter:
  - On a MULT grant, load MULT_LAT-1.
  - Otherwise, if nonzero, decrement.
  - mult_busy = counter != 0.
  - With MULT_LAT = 1 the multiplier is never busy, so back-to-back MULT issue is allowed.
- Mispredict does not affect the counter: the unit finishes regardless.
- Simultaneous events:
  - ls_ready low blocks every LOAD/STORE grant that cycle.
  - A MULT issued in the same cycle as a mispredict that squashes it still loads the counter.
- Reset, including mid-operation: iss_valid = 0, iss_packet = 0, rr_ptr = 0, counter = 0, mult_busy = 0. No grants are made while reset is high.
- Empty RS or no eligible entries: rs_data_issuing = 0 and all slots invalid next cycle.

Test Plan:
- Reset, then entries 3 and 7 valid ALU with both sources ready -> rs_data_issuing = 0x0088; next cycle iss_valid = 2'b11, slot0 = entry 3, slot1 = entry 7; rr_ptr = 8.
- Entries 0, 1, 2 ALU ready, N = 2 -> entries 0 and 1 granted, rr_ptr = 2; with the same entries still valid next cycle, entry 2 is granted first (round-robin fairness and wrap).
- MULT entries 4 and 5 ready with MULT_LAT = 4 -> entry 4 issues; mult_busy high for 3 cycles; entry 5 issues on cycle 4 after the first grant.
- LOAD at entry 1 with sq_mask = 0x2, STORE at entry 2, ls_ready = 1 -> only entry 2 granted; after sq_mask becomes 0, entry 1 granted; with ls_ready = 0, neither is granted.
- Granted ALU with b_mask = 0x4, b_mm_resolve = 0x4, b_mm_mispred = 1 in the grant cycle -> iss_valid slot = 0. Repeat with mispred = 0 -> slot valid with b_mask = 0.
- Reset asserted while mult_busy = 1 and slots valid -> next cycle iss_valid = 0, mult_busy = 0, rr_ptr = 0; during reset rs_data_issuing = 0 despite ready entries.
